// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the CPU instruction sequencer: state encodings,
// RV32 major opcodes and opcode classification helpers.
package cpu_sequencer_pkg;

    localparam int unsigned SEQ_STATE_WIDTH = 3;
    localparam int unsigned OPCODE_WIDTH    = 7;

    typedef enum logic [SEQ_STATE_WIDTH-1:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_FETCH     = 3'd1,
        SEQ_DECODE    = 3'd2,
        SEQ_EXECUTE   = 3'd3,
        SEQ_MEMORY    = 3'd4,
        SEQ_WRITEBACK = 3'd5,
        SEQ_FAULT     = 3'd6
    } seq_state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_WIDTH-1:0] OP_I_ALU  = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_WIDTH-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_WIDTH-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = 7'b1100011;

    // Instruction needs a data-memory access
    function automatic logic op_is_mem(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // Legal instruction that completes without a data-memory access
    function automatic logic op_is_nonmem(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_R)   || (op == OP_I_ALU) || (op == OP_LUI)  ||
               (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR) ||
               (op == OP_BRANCH);
    endfunction

    // Instruction writes a destination register
    function automatic logic op_writes_rd(input logic [OPCODE_WIDTH-1:0] op);
        return !((op == OP_STORE) || (op == OP_BRANCH));
    endfunction

endpackage

// File: rtl/sequencer_wait_timer.sv
// Wait-cycle counter for memory handshakes; flags a timeout when the
// current waiting cycle is the last one allowed and no ack arrived.
module sequencer_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Timeout
);

    logic [TIMEOUT_WIDTH-1:0] count;

    // Counter: held at zero outside a wait, counts unanswered wait cycles
    always_ff @(posedge i_Clock) begin
        if (i_Reset || i_Clear) begin
            count <= '0;
        end else if (i_Enable) begin
            count <= count + TIMEOUT_WIDTH'(1);
        end
    end

    // Enable already excludes an ack this cycle, so a same-cycle ack wins
    assign o_Timeout = i_Enable && (count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH, DECODE, EXECUTE, MEMORY,
// WRITEBACK with req/ack timeouts to a sticky FAULT state.
// Optional macro CPU_SEQUENCER_PERF_COUNTERS_EN adds cycle/retire counters.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Run,
    input  logic [6:0]  i_Op_Code,
    output logic        o_Imem_Req,
    input  logic        i_Imem_Ack,
    output logic        o_Ir_Load,
    output logic        o_Control_Enable,
    output logic        o_Dmem_Req,
    output logic        o_Dmem_Write,
    input  logic        i_Dmem_Ack,
    output logic        o_Reg_Write_Strobe,
    output logic        o_Pc_Update,
    output logic        o_Retired,
    output logic        o_Fault,
`ifdef CPU_SEQUENCER_PERF_COUNTERS_EN
    output logic [31:0] o_Cycle_Count,
    output logic [31:0] o_Retired_Count,
`endif
    output logic [2:0]  o_State
);

    seq_state_t state;
    seq_state_t state_next;
    logic       waiting;
    logic       wait_ack;
    logic       timeout_c;

    assign waiting  = (state == SEQ_FETCH) || (state == SEQ_MEMORY);
    assign wait_ack = (state == SEQ_FETCH) ? i_Imem_Ack : i_Dmem_Ack;
    assign o_State  = state;

    sequencer_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_wait_timer (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_Clear   (!waiting),
        .i_Enable  (waiting && !wait_ack),
        .o_Timeout (timeout_c)
    );

    // State register
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_next         = state;
        o_Imem_Req         = 1'b0;
        o_Ir_Load          = 1'b0;
        o_Control_Enable   = 1'b0;
        o_Dmem_Req         = 1'b0;
        o_Dmem_Write       = 1'b0;
        o_Reg_Write_Strobe = 1'b0;
        o_Pc_Update        = 1'b0;
        o_Retired          = 1'b0;
        o_Fault            = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (i_Run) state_next = SEQ_FETCH;
            end
            SEQ_FETCH: begin
                o_Imem_Req = 1'b1;
                o_Ir_Load  = i_Imem_Ack;
                if (i_Imem_Ack)     state_next = SEQ_DECODE;
                else if (timeout_c) state_next = SEQ_FAULT;
            end
            SEQ_DECODE: begin
                o_Control_Enable = 1'b1;
                state_next       = SEQ_EXECUTE;
            end
            SEQ_EXECUTE: begin
                o_Control_Enable = 1'b1;
                if (op_is_mem(i_Op_Code))         state_next = SEQ_MEMORY;
                else if (op_is_nonmem(i_Op_Code)) state_next = SEQ_WRITEBACK;
                else                              state_next = SEQ_FAULT;
            end
            SEQ_MEMORY: begin
                o_Control_Enable = 1'b1;
                o_Dmem_Req       = 1'b1;
                o_Dmem_Write     = (i_Op_Code == OP_STORE);
                if (i_Dmem_Ack)     state_next = SEQ_WRITEBACK;
                else if (timeout_c) state_next = SEQ_FAULT;
            end
            SEQ_WRITEBACK: begin
                o_Control_Enable   = 1'b1;
                o_Pc_Update        = 1'b1;
                o_Retired          = 1'b1;
                o_Reg_Write_Strobe = op_writes_rd(i_Op_Code);
                state_next         = i_Run ? SEQ_FETCH : SEQ_IDLE;
            end
            SEQ_FAULT: begin
                o_Fault = 1'b1;
            end
            default: begin
                state_next = SEQ_IDLE;
            end
        endcase
    end

`ifdef CPU_SEQUENCER_PERF_COUNTERS_EN
    // Performance counters: active cycles and retired instructions
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Cycle_Count   <= '0;
            o_Retired_Count <= '0;
        end else begin
            if ((state != SEQ_IDLE) && (state != SEQ_FAULT))
                o_Cycle_Count <= o_Cycle_Count + 32'd1;
            if (o_Retired)
                o_Retired_Count <= o_Retired_Count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer (TIMEOUT_CYCLES=4).
module tb_cpu_sequencer;

    logic        i_Clock = 1'b0;
    logic        i_Reset;
    logic        i_Run;
    logic [6:0]  i_Op_Code;
    logic        i_Imem_Ack;
    logic        i_Dmem_Ack;
    logic        o_Imem_Req, o_Ir_Load, o_Control_Enable, o_Dmem_Req, o_Dmem_Write;
    logic        o_Reg_Write_Strobe, o_Pc_Update, o_Retired, o_Fault;
    logic [2:0]  o_State;
`ifdef CPU_SEQUENCER_PERF_COUNTERS_EN
    logic [31:0] o_Cycle_Count, o_Retired_Count;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] BAD  = 7'b1111111;

    // Output vector: {imem_req, ir_load, ctrl_en, dmem_req, dmem_wr, rws, pc_upd, retired, fault}
    localparam logic [8:0] O_NONE   = 9'b000000000;
    localparam logic [8:0] O_FETCHA = 9'b110000000;
    localparam logic [8:0] O_FETCH  = 9'b100000000;
    localparam logic [8:0] O_CTRL   = 9'b001000000;
    localparam logic [8:0] O_LOAD   = 9'b001100000;
    localparam logic [8:0] O_STORE  = 9'b001110000;
    localparam logic [8:0] O_WB_RD  = 9'b001001110;
    localparam logic [8:0] O_WB_NRD = 9'b001000110;
    localparam logic [8:0] O_FAULT  = 9'b000000001;

    cpu_sequencer #(
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_WIDTH  (8)
    ) dut (
        .i_Clock            (i_Clock),
        .i_Reset            (i_Reset),
        .i_Run              (i_Run),
        .i_Op_Code          (i_Op_Code),
        .o_Imem_Req         (o_Imem_Req),
        .i_Imem_Ack         (i_Imem_Ack),
        .o_Ir_Load          (o_Ir_Load),
        .o_Control_Enable   (o_Control_Enable),
        .o_Dmem_Req         (o_Dmem_Req),
        .o_Dmem_Write       (o_Dmem_Write),
        .i_Dmem_Ack         (i_Dmem_Ack),
        .o_Reg_Write_Strobe (o_Reg_Write_Strobe),
        .o_Pc_Update        (o_Pc_Update),
        .o_Retired          (o_Retired),
        .o_Fault            (o_Fault),
`ifdef CPU_SEQUENCER_PERF_COUNTERS_EN
        .o_Cycle_Count      (o_Cycle_Count),
        .o_Retired_Count    (o_Retired_Count),
`endif
        .o_State            (o_State)
    );

    always #5 i_Clock = ~i_Clock;

    function automatic logic [8:0] outs();
        return {o_Imem_Req, o_Ir_Load, o_Control_Enable, o_Dmem_Req, o_Dmem_Write,
                o_Reg_Write_Strobe, o_Pc_Update, o_Retired, o_Fault};
    endfunction

    task automatic step();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Check state and full output vector after inputs settle
    task automatic chk_so(input string tag, input logic [2:0] st, input logic [8:0] o);
        #1;
        chk({tag, "_state"}, 32'(o_State), 32'(st));
        chk({tag, "_outs"}, 32'(outs()), 32'(o));
    endtask

    initial begin
        i_Reset = 1'b1; i_Run = 1'b0; i_Op_Code = '0;
        i_Imem_Ack = 1'b0; i_Dmem_Ack = 1'b0;
        step(); step();
        chk_so("reset", 3'd0, O_NONE);
`ifdef CPU_SEQUENCER_PERF_COUNTERS_EN
        chk("reset_cyc", o_Cycle_Count, 32'd0);
        chk("reset_ret", o_Retired_Count, 32'd0);
`endif
        i_Reset = 1'b0;

        // ADDI, zero-wait fetch
        i_Run = 1'b1; i_Imem_Ack = 1'b1; i_Op_Code = ADDI;
        step(); chk_so("addi_fetch", 3'd1, O_FETCHA);
        step(); chk_so("addi_dec",   3'd2, O_CTRL);
        step(); chk_so("addi_exe",   3'd3, O_CTRL);
        step(); i_Run = 1'b0; chk_so("addi_wb", 3'd5, O_WB_RD);
        step(); chk_so("addi_idle",  3'd0, O_NONE);

        // LW with data ack on the 4th MEMORY cycle
        i_Run = 1'b1; i_Op_Code = LW;
        step(); chk_so("lw_fetch", 3'd1, O_FETCHA);
        step(); chk_so("lw_dec",   3'd2, O_CTRL);
        step(); chk_so("lw_exe",   3'd3, O_CTRL);
        step(); chk_so("lw_mem1",  3'd4, O_LOAD);
        step(); chk_so("lw_mem2",  3'd4, O_LOAD);
        step(); chk_so("lw_mem3",  3'd4, O_LOAD);
        step(); i_Dmem_Ack = 1'b1; i_Run = 1'b0; chk_so("lw_mem4", 3'd4, O_LOAD);
        step(); i_Dmem_Ack = 1'b0; chk_so("lw_wb", 3'd5, O_WB_RD);
        step(); chk_so("lw_idle", 3'd0, O_NONE);

        // SW then BEQ back to back
        i_Run = 1'b1; i_Op_Code = SW; i_Dmem_Ack = 1'b1;
        step(); chk_so("sw_fetch", 3'd1, O_FETCHA);
        step(); chk_so("sw_dec",   3'd2, O_CTRL);
        step(); chk_so("sw_exe",   3'd3, O_CTRL);
        step(); chk_so("sw_mem",   3'd4, O_STORE);
        step(); chk_so("sw_wb",    3'd5, O_WB_NRD);
        step(); i_Op_Code = BEQ; chk_so("beq_fetch", 3'd1, O_FETCHA);
        step(); chk_so("beq_dec",  3'd2, O_CTRL);
        step(); chk_so("beq_exe",  3'd3, O_CTRL);
        step(); i_Run = 1'b0; chk_so("beq_wb", 3'd5, O_WB_NRD);
        step(); i_Dmem_Ack = 1'b0; chk_so("beq_idle", 3'd0, O_NONE);

        // Fetch timeout: no ack for 4 FETCH cycles
        i_Run = 1'b1; i_Imem_Ack = 1'b0; i_Op_Code = ADDI;
        step(); chk_so("to_fetch1", 3'd1, O_FETCH);
        step(); step();
        step(); chk_so("to_fetch4", 3'd1, O_FETCH);
        step(); i_Run = 1'b0; chk_so("to_fault", 3'd6, O_FAULT);
        step(); i_Imem_Ack = 1'b1;
        step(); chk_so("to_sticky", 3'd6, O_FAULT);
        i_Reset = 1'b1; i_Imem_Ack = 1'b0;
        step(); chk_so("to_reset", 3'd0, O_NONE);
        i_Reset = 1'b0;

        // Ack on the last allowed cycle wins, then illegal opcode faults
        i_Run = 1'b1;
        step(); step(); step();
        step(); i_Imem_Ack = 1'b1; chk_so("late_ack", 3'd1, O_FETCHA);
        step(); i_Imem_Ack = 1'b0; i_Op_Code = BAD; chk_so("late_dec", 3'd2, O_CTRL);
        step(); chk_so("bad_exe", 3'd3, O_CTRL);
        step(); chk_so("bad_fault", 3'd6, O_FAULT);
        i_Reset = 1'b1;
        step(); i_Reset = 1'b0; chk_so("bad_reset", 3'd0, O_NONE);

        // Reset in MEMORY with a request outstanding
        i_Op_Code = LW; i_Imem_Ack = 1'b1;
        step(); step(); step();
        step(); chk_so("rm_mem", 3'd4, O_LOAD);
        i_Reset = 1'b1;
        step(); chk_so("rm_reset", 3'd0, O_NONE);
        i_Reset = 1'b0;

`ifdef CPU_SEQUENCER_PERF_COUNTERS_EN
        // Three back-to-back ADDIs after the reset above
        i_Op_Code = ADDI; i_Run = 1'b1;
        for (int i = 0; i < 12; i++) step();
        i_Run = 1'b0;
        step(); chk_so("perf_idle", 3'd0, O_NONE);
        chk("perf_cyc", o_Cycle_Count, 32'd12);
        chk("perf_ret", o_Retired_Count, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle instruction sequencer for the CPU core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Gates the decoder enable, instruction-register load, data-memory request, register-file write strobe and PC update.
- Handles instruction/data memory req/ack handshakes with timeout-to-fault; sits between the memory interfaces and the decoder/datapath.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for any ack before FAULT; legal 1..255.
- TIMEOUT_WIDTH, 8: width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
- i_Clock  in  1  sole clock, rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Run  in  1  permit new fetches.
- i_Op_Code  in  7  opcode from instruction register; valid from DECODE onward.
- o_Imem_Req  out  1  instruction fetch request.
- i_Imem_Ack  in  1  fetch data valid this cycle.
- o_Ir_Load  out  1  latch instruction word.
- o_Control_Enable  out  1  enable for the instruction decoder.
- o_Dmem_Req  out  1  data memory request.
- o_Dmem_Write  out  1  request is a store.
- i_Dmem_Ack  in  1  data access complete.
- o_Reg_Write_Strobe  out  1  qualifies the decoder's register write enable.
- o_Pc_Update  out  1  commit next PC.
- o_Retired  out  1  one-cycle pulse per completed instruction.
- o_Fault  out  1  sticky fault flag.
- o_State  out  3  current state encoding.

Behaviour:
- Reset: clock and reset are as Already decided. Reset forces state IDLE, clears the wait counter and fault, and all outputs read 0. This applies mid-instruction too; any outstanding request drops on the next edge.
- States (3-bit): IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, FAULT=6; 7 is unreachable and recovers to IDLE.
- Outputs: Moore decode of registered state and opcode, except o_Ir_Load = (FETCH and i_Imem_Ack).
- IDLE: i_Run=1 -> FETCH.
- FETCH: o_Imem_Req=1, held until ack. Ack -> DECODE.
- DECODE: o_Control_Enable=1 (decoder settles). Always -> EXECUTE.
- EXECUTE: o_Control_Enable=1.
  - Load (0000011) or store (0100011) -> MEMORY.
  - Legal non-memory opcode (R, I-ALU, LUI, AUIPC, JAL, JALR, BRANCH) -> WRITEBACK.
  - Any other opcode -> FAULT.
- MEMORY: o_Control_Enable=1, o_Dmem_Req=1, o_Dmem_Write=1 iff store; held until i_Dmem_Ack, then -> WRITEBACK.
- WRITEBACK: o_Control_Enable=1, o_Pc_Update=1, o_Retired=1.
  - o_Reg_Write_Strobe=1 unless opcode is store or branch.
  - Next state: FETCH if i_Run=1, else IDLE.
- FAULT: o_Fault=1; all other outputs 0; exits only via reset.
- Wait counter:
  - Clears on entry to FETCH/MEMORY and increments each waiting cycle.
  - Reaching TIMEOUT_CYCLES with no ack -> FAULT.
  - Ack in the same cycle the limit is reached: ack wins.
- i_Run deasserted mid-instruction: the instruction completes; the sequencer parks in IDLE after WRITEBACK.
- Spurious ack outside the waiting state is ignored.
- Latency with zero-wait acks: non-memory instruction 4 cycles, load/store 5. Each wait cycle adds 1.

Optional Feature:
- Macro: CPU_SEQUENCER_PERF_COUNTERS_EN.
- Defined: adds outputs o_Cycle_Count[31:0] (increments every non-reset cycle outside IDLE/FAULT) and o_Retired_Count[31:0] (increments on o_Retired). Both reset to 0 and wrap 0xFFFFFFFF -> 0.
- Undefined: neither port nor its registers exist.

Decomposition:
- Shared header cpu_sequencer.vh: state encodings, SEQ_STATE_WIDTH=3. Reuse the OP_* opcode constants from the control-unit header; no duplicates.
- One sub-module: sequencer_wait_timer, holding the wait counter, clear/enable inputs and timeout output.

Test Plan:
- ADDI (0010011), zero-wait acks, i_Run=1 -> states 1,2,3,5; o_Retired and o_Reg_Write_Strobe high at cycle 4; o_Dmem_Req never high.
- LW with i_Dmem_Ack delayed 3 cycles -> o_Dmem_Req high 4 cycles, o_Dmem_Write=0, strobe in WRITEBACK; total 8 cycles.
- SW then BEQ -> o_Dmem_Write=1 for SW; o_Reg_Write_Strobe=0 in both WRITEBACKs; o_Pc_Update=1 in both.
- i_Imem_Ack withheld with TIMEOUT_CYCLES=4 -> FAULT after 4 wait cycles, o_Fault=1 held; ack asserted on the 4th cycle instead -> DECODE.
- Opcode 1111111 -> FAULT from EXECUTE; reset asserted in MEMORY mid-request -> IDLE next edge, all outputs 0.
- With CPU_SEQUENCER_PERF_COUNTERS_EN, 3 ADDIs back-to-back -> o_Retired_Count=3, o_Cycle_Count=12.
